// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer.
// Holds the per-channel FSM state encoding and counter-width math.
package button_debouncer_pkg;

    // Per-channel debounce FSM states
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } db_state_e;

    // $clog2 that never returns 0, so a counter is always at least 1 bit
    function automatic int clog2_safe(input int value);
        int result;
        if (value < 2) begin
            result = 1;
        end else begin
            result = $clog2(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounced button channel: 2-flop synchronizer, settle FSM,
// stability counter, hold counter and registered event strobes.
module button_debounce_chan
    import button_debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   HOLD_CYCLES     = 50000000,
    parameter logic RELEASED_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int CW = clog2_safe(DEBOUNCE_CYCLES);
    localparam int HW = clog2_safe(HOLD_CYCLES) + 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam bit            HOLD_EN   = (HOLD_CYCLES > 0);
    localparam bit            INSTANT   = (DEBOUNCE_CYCLES == 1);

    logic           r_sync1;
    logic           r_sync2;
    logic           r_db;
    db_state_e      r_state;
    logic [CW-1:0]  r_cnt;
    logic [HW-1:0]  r_hcnt;
    logic           r_press;
    logic           r_release;
    logic           r_hold;

    logic           w_diff;
    logic           w_accept;
    db_state_e      w_state_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_press_nxt;
    logic           w_release_nxt;
    logic           w_pressed;
    logic [HW-1:0]  w_hcnt_inc;
    logic [HW-1:0]  w_hcnt_nxt;
    logic           w_hold_nxt;

    assign w_diff     = (r_sync2 != r_db);
    assign w_pressed  = (r_db != RELEASED_LEVEL);
    assign w_hcnt_inc = r_hcnt + HOLD_ONE;

    // Two-flop synchronizer; released level out of reset avoids a fake edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= RELEASED_LEVEL;
            r_sync2 <= RELEASED_LEVEL;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State register: FSM state, settle count, debounced level, strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_STABLE;
            r_cnt     <= '0;
            r_db      <= RELEASED_LEVEL;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            if (w_accept) begin
                r_db <= r_sync2;
            end
        end
    end

    // Next-state logic: count consecutive mismatches, drop back on a bounce
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (w_diff) begin
                    if (INSTANT) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETTLING;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_SETTLING: begin
                if (!w_diff) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: direction of the accepted level picks the strobe
    always_comb begin
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_accept) begin
            if (r_sync2 == RELEASED_LEVEL) begin
                w_release_nxt = 1'b1;
            end else begin
                w_press_nxt = 1'b1;
            end
        end
    end

    // Hold counter next value: saturates so only one hold strobe per press
    always_comb begin
        w_hcnt_nxt = '0;
        w_hold_nxt = 1'b0;
        if (HOLD_EN && w_pressed) begin
            if (r_hcnt != HOLD_LAST) begin
                w_hcnt_nxt = w_hcnt_inc;
                w_hold_nxt = (w_hcnt_inc == HOLD_LAST);
            end else begin
                w_hcnt_nxt = r_hcnt;
            end
        end
    end

    // Hold counter and hold strobe registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hcnt <= '0;
            r_hold <= 1'b0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_hold <= w_hold_nxt;
        end
    end

    assign btn_db        = r_db;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign hold_pulse    = r_hold;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner feeding the button PIO in_port.
// Each channel is debounced independently by button_debounce_chan.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int   WIDTH           = 2,
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   HOLD_CYCLES     = 50000000,
    parameter logic RELEASED_LEVEL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_db,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] hold_pulse
);

    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;
    logic [WIDTH-1:0] w_hold;

    // One independent debounce channel per button
    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        button_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .RELEASED_LEVEL  (RELEASED_LEVEL)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .btn_raw       (btn_raw[g]),
            .btn_db        (w_db[g]),
            .press_pulse   (w_press[g]),
            .release_pulse (w_release[g]),
            .hold_pulse    (w_hold[g])
        );
    end

    assign btn_db        = w_db;
    assign press_pulse   = w_press;
    assign release_pulse = w_release;
    assign hold_pulse    = w_hold;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE=4, HOLD=10).
// Directed scenarios plus random raw activity against a reference model.
module tb_button_debouncer;

    localparam int W    = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] btn_raw = 2'b11;
    logic [W-1:0] btn_db;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
    logic [W-1:0] hold_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .RELEASED_LEVEL  (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .btn_db        (btn_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: the raw pin reaches the decision point two edges
    // late; a level is accepted once it has differed for DEB edges in a row.
    logic [W-1:0] m_s1 = '1;
    logic [W-1:0] m_s2 = '1;
    logic [W-1:0] m_db = '1;
    logic [W-1:0] m_p = '0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] m_h = '0;
    int           m_run [W];
    int           m_age [W];
    logic [W-1:0] m_nd;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_s1 = '1;
            m_s2 = '1;
            m_db = '1;
            m_p  = '0;
            m_r  = '0;
            m_h  = '0;
            for (int c = 0; c < W; c++) begin
                m_run[c] = 0;
                m_age[c] = 0;
            end
        end else begin
            m_p  = '0;
            m_r  = '0;
            m_h  = '0;
            m_nd = m_db;
            for (int c = 0; c < W; c++) begin
                if (m_db[c] == 1'b0) begin
                    if (m_age[c] < HOLD) begin
                        m_age[c]++;
                        if (m_age[c] == HOLD) m_h[c] = 1'b1;
                    end
                end else begin
                    m_age[c] = 0;
                end
                if (m_s2[c] != m_db[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == DEB) begin
                    m_nd[c]  = m_s2[c];
                    m_run[c] = 0;
                    if (m_s2[c]) m_r[c] = 1'b1;
                    else m_p[c] = 1'b1;
                end
            end
            m_db = m_nd;
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    logic [7:0] obs;
    logic [7:0] mdl;
    assign obs = {btn_db, press_pulse, release_pulse, hold_pulse};
    assign mdl = {m_db, m_p, m_r, m_h};

    task automatic test_reset();
        reset_n = 1'b0;
        btn_raw = 2'b11;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 8'b11_00_00_00) begin
                n_fail++;
                $display("FAIL reset_hold: got %b want %b", obs, 8'b11_00_00_00);
            end
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 8'b11_00_00_00) begin
                n_fail++;
                $display("FAIL reset_release: got %b want %b", obs, 8'b11_00_00_00);
            end
        end
    endtask

    task automatic test_single_press();
        int fall = -1;
        int pn   = -1;
        int pc   = 0;
        btn_raw[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== mdl) begin
                n_fail++;
                $display("FAIL press_model: got %b want %b", obs, mdl);
            end
            if (fall < 0 && btn_db[0] == 1'b0) fall = n;
            if (press_pulse[0]) begin
                pc++;
                pn = n;
            end
        end
        n_checks++;
        if (fall != 6 || pn != 6 || pc != 1) begin
            n_fail++;
            $display("FAIL press_latency: fall %0d pulse %0d x%0d want 6 6 x1",
                     fall, pn, pc);
        end
        btn_raw[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            n_checks++;
            if (obs !== mdl) begin
                n_fail++;
                $display("FAIL press_release: got %b want %b", obs, mdl);
            end
        end
    endtask

    task automatic test_bounce();
        int fall = -1;
        int pc   = 0;
        for (int i = 0; i < 4; i++) begin
            btn_raw[0] = (i % 2 == 1);
            repeat (2) begin
                @(negedge clk);
                n_checks++;
                if (btn_db[0] !== 1'b1 || press_pulse[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_hold: db %b press %b want 1 0",
                             btn_db[0], press_pulse[0]);
                end
            end
        end
        btn_raw[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== mdl) begin
                n_fail++;
                $display("FAIL bounce_model: got %b want %b", obs, mdl);
            end
            if (fall < 0 && btn_db[0] == 1'b0) fall = n;
            if (press_pulse[0]) pc++;
        end
        n_checks++;
        if (fall != 6 || pc != 1) begin
            n_fail++;
            $display("FAIL bounce_latency: fall %0d x%0d want 6 x1", fall, pc);
        end
        btn_raw[0] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_hold();
        int fall = -1;
        int hn   = -1;
        int rn   = -1;
        int pc   = 0;
        int hc   = 0;
        int rc   = 0;
        btn_raw[1] = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            if (n == 21) btn_raw[1] = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== mdl) begin
                n_fail++;
                $display("FAIL hold_model: got %b want %b", obs, mdl);
            end
            if (fall < 0 && btn_db[1] == 1'b0) fall = n;
            if (press_pulse[1]) pc++;
            if (hold_pulse[1]) begin
                hc++;
                hn = n;
            end
            if (release_pulse[1]) begin
                rc++;
                rn = n;
            end
        end
        n_checks++;
        if (fall != 6 || hn - fall != 10 || rn != 26) begin
            n_fail++;
            $display("FAIL hold_timing: fall %0d hold %0d rel %0d want 6 16 26",
                     fall, hn, rn);
        end
        n_checks++;
        if (pc != 1 || hc != 1 || rc != 1) begin
            n_fail++;
            $display("FAIL hold_counts: p %0d h %0d r %0d want 1 1 1", pc, hc, rc);
        end
    endtask

    task automatic test_reset_mid();
        int fall = -1;
        btn_raw[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== 8'b11_00_00_00) begin
            n_fail++;
            $display("FAIL midreset_edge: got %b want %b", obs, 8'b11_00_00_00);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== mdl) begin
                n_fail++;
                $display("FAIL midreset_model: got %b want %b", obs, mdl);
            end
            if (fall < 0 && btn_db[0] == 1'b0) fall = n;
        end
        n_checks++;
        if (fall != 6) begin
            n_fail++;
            $display("FAIL midreset_restart: fall %0d want 6", fall);
        end
        btn_raw[0] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_both();
        int fall = -1;
        logic [1:0] pf = 2'b00;
        btn_raw = 2'b00;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_checks++;
            if (btn_db !== 2'b11 && btn_db !== 2'b00) begin
                n_fail++;
                $display("FAIL both_split: got %b want 11 or 00", btn_db);
            end
            if (fall < 0 && btn_db == 2'b00) begin
                fall = n;
                pf   = press_pulse;
            end
        end
        n_checks++;
        if (fall != 6 || pf != 2'b11) begin
            n_fail++;
            $display("FAIL both_press: fall %0d press %b want 6 11", fall, pf);
        end
        btn_raw = 2'b11;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        for (int s = 0; s < 80; s++) begin
            btn_raw = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 24) != 0);
            for (int k = 0; k < $urandom_range(1, 9); k++) begin
                @(negedge clk);
                reset_n = 1'b1;
                n_checks++;
                if (obs !== mdl) begin
                    n_fail++;
                    $display("FAIL random_model: got %b want %b", obs, mdl);
                end
                n_checks++;
                if ((press_pulse & release_pulse) !== 2'b00) begin
                    n_fail++;
                    $display("FAIL random_excl: press %b release %b want disjoint",
                             press_pulse, release_pulse);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_hold();
        test_reset_mid();
        test_both();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
